// File: rtl/block_transfer_seq_pkg.sv
// Shared types and constants for the LDM/STM block transfer sequencer.
//   state_e    : sequencer state (IDLE/XFER/WB/DONE)
//   WORD_BYTES : address stride per transferred register
//   NREGS      : width of the register list
package block_transfer_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_WB,
    ST_DONE
  } state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned NREGS      = 16;

endpackage

// File: rtl/block_transfer_seq_if.sv
// Memory bus between the block transfer sequencer and the bus fabric.
//   mem_req/mem_we/mem_addr/mem_wdata : request side, held until mem_ack
//   mem_rdata/mem_ack/mem_err         : response side, mem_err qualified by mem_ack
// master = sequencer, slave = memory/bus.
interface block_transfer_seq_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              mem_err;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack, mem_err
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack, mem_err
  );

endinterface

// File: rtl/block_transfer_seq_reg_list_scan.sv
// Combinational scan of a 16-bit register list.
//   list   : in  register list, bit i => Ri
//   lowest : out index of lowest set bit (0 when list is empty)
//   count  : out number of set bits
module reg_list_scan
  import block_transfer_seq_pkg::*;
(
  input  logic [15:0] list,
  output logic [3:0]  lowest,
  output logic [4:0]  count
);

  always_comb begin
    lowest = '0;
    count  = '0;
    // Walk from the top down so the last hit is the lowest set bit.
    for (int unsigned i = NREGS; i > 0; i--) begin
      if (list[i-1]) begin
        lowest = 4'(i - 1);
      end
      count = count + 5'(list[i-1]);
    end
  end

endmodule

// File: rtl/block_transfer_seq.sv
// LDM/STM sequencer. Walks a register list lowest-first: stores read the
// register file and write memory, loads read memory and write the register
// file; optionally writes the updated base back at the end.
//   clk, rst_n                    : clock, async active-low reset
//   start, reg_list, is_load, up,
//   pre, wback, base_reg, base_val: transfer command, sampled in IDLE
//   rf_rd_addr / rf_rd_data       : register file async read port
//   rf_wr_en/addr/data            : register file write port
//   bus                           : memory bus (master side)
//   busy, done, err               : status; done pulses one cycle, err valid with done
module block_transfer_seq
  import block_transfer_seq_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [15:0]          reg_list,
  input  logic                 is_load,
  input  logic                 up,
  input  logic                 pre,
  input  logic                 wback,
  input  logic [3:0]           base_reg,
  input  logic [ADDR_W-1:0]    base_val,
  output logic [3:0]           rf_rd_addr,
  input  logic [DATA_W-1:0]    rf_rd_data,
  output logic                 rf_wr_en,
  output logic [3:0]           rf_wr_addr,
  output logic [DATA_W-1:0]    rf_wr_data,
  block_transfer_seq_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  state_e            state_q, state_d;
  logic [15:0]       list_q, list_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] new_base_q, new_base_d;
  logic              is_load_q, is_load_d;
  logic              wb_en_q, wb_en_d;
  logic [3:0]        base_reg_q, base_reg_d;
  logic              err_q, err_d;

  logic [3:0]        in_lowest;
  logic [4:0]        in_count;
  logic [3:0]        cur_idx;
  logic [4:0]        cur_count;
  logic [ADDR_W-1:0] span;
  logic [15:0]       list_next;
  logic              xfer;

  reg_list_scan u_scan_in (
    .list   (reg_list),
    .lowest (in_lowest),
    .count  (in_count)
  );

  reg_list_scan u_scan_cur (
    .list   (list_q),
    .lowest (cur_idx),
    .count  (cur_count)
  );

  assign span      = ADDR_W'(in_count) * ADDR_W'(WORD_BYTES);
  assign list_next = list_q & ~(16'd1 << cur_idx);
  assign xfer      = (state_q == ST_XFER);

  always_comb begin
    state_d    = state_q;
    list_d     = list_q;
    addr_d     = addr_q;
    new_base_d = new_base_q;
    is_load_d  = is_load_q;
    wb_en_d    = wb_en_q;
    base_reg_d = base_reg_q;
    err_d      = err_q;
    rf_wr_en   = 1'b0;
    rf_wr_addr = '0;
    rf_wr_data = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          list_d     = reg_list;
          is_load_d  = is_load;
          base_reg_d = base_reg;
          err_d      = 1'b0;
          // A load that includes the base register keeps the loaded value.
          wb_en_d    = wback & ~(is_load & reg_list[base_reg]);
          new_base_d = up ? (base_val + span) : (base_val - span);
          if (up) begin
            addr_d = pre ? (base_val + ADDR_W'(WORD_BYTES)) : base_val;
          end else begin
            addr_d = pre ? (base_val - span) : (base_val - span + ADDR_W'(WORD_BYTES));
          end
          state_d = (in_count == '0) ? ST_DONE : ST_XFER;
        end
      end

      ST_XFER: begin
        if (bus.mem_ack) begin
          if (bus.mem_err) begin
            err_d   = 1'b1;
            list_d  = '0;
            state_d = ST_DONE;
          end else begin
            if (is_load_q) begin
              rf_wr_en   = 1'b1;
              rf_wr_addr = cur_idx;
              rf_wr_data = bus.mem_rdata;
            end
            list_d = list_next;
            addr_d = addr_q + ADDR_W'(WORD_BYTES);
            if (list_next == '0) begin
              state_d = wb_en_q ? ST_WB : ST_DONE;
            end
          end
        end
      end

      ST_WB: begin
        rf_wr_en   = 1'b1;
        rf_wr_addr = base_reg_q;
        rf_wr_data = DATA_W'(new_base_q);
        state_d    = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      list_q     <= '0;
      addr_q     <= '0;
      new_base_q <= '0;
      is_load_q  <= 1'b0;
      wb_en_q    <= 1'b0;
      base_reg_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      list_q     <= list_d;
      addr_q     <= addr_d;
      new_base_q <= new_base_d;
      is_load_q  <= is_load_d;
      wb_en_q    <= wb_en_d;
      base_reg_q <= base_reg_d;
      err_q      <= err_d;
    end
  end

  // Bus and read-port outputs depend only on state flops, so they stay
  // stable while a beat waits for mem_ack; store data follows the RF read.
  assign bus.mem_req   = xfer;
  assign bus.mem_we    = xfer & ~is_load_q;
  assign bus.mem_addr  = xfer ? (addr_q & ~ADDR_W'(3)) : '0;
  assign bus.mem_wdata = (xfer & ~is_load_q) ? rf_rd_data : '0;
  assign rf_rd_addr    = xfer ? cur_idx : '0;

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign err  = done & err_q;

endmodule

// File: tb/tb_block_transfer_seq.sv
module tb_block_transfer_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] reg_list = '0;
  logic        is_load = 1'b0;
  logic        up = 1'b0;
  logic        pre = 1'b0;
  logic        wback = 1'b0;
  logic [3:0]  base_reg = '0;
  logic [31:0] base_val = '0;
  logic [3:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        rf_wr_en;
  logic [3:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        busy, done, err;

  logic [31:0] env_rf [16];
  int n_checks = 0;
  int n_pass   = 0;

  block_transfer_seq_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  block_transfer_seq #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .reg_list   (reg_list),
    .is_load    (is_load),
    .up         (up),
    .pre        (pre),
    .wback      (wback),
    .base_reg   (base_reg),
    .base_val   (base_val),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .bus        (bus_if.master),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  assign rf_rd_data = env_rf[rf_rd_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A00_00C3;
  endfunction

  task automatic fill_rf();
    for (int i = 0; i < 16; i++) env_rf[i] = $urandom;
  endtask

  // dly >= 0: every beat waits dly cycles for ack; dly < 0: random 0..2.
  // errbeat: beat index that returns mem_err (>= n or < 0 means none).
  task automatic run_txn(input logic [15:0] lst, input logic ld, input logic u, input logic p,
                         input logic w, input logic [3:0] br, input logic [31:0] base,
                         input int dly, input int errbeat);
    int          order[$];
    logic [31:0] snap[16];
    logic [31:0] exp_addr[$], exp_data[$], exp_wa[$], exp_wd[$];
    int          d[16];
    int          n, nbeats, exp_done, cyc, bi, wc, wi;
    logic [31:0] first, nb, a;
    bit          has_err, do_wb, seen_done, ack, pend;
    logic [3:0]  pa;
    logic [31:0] pd;

    // Reference: the architectural effect of the instruction.
    n = 0;
    for (int i = 0; i < 16; i++) begin
      snap[i] = env_rf[i];
      if (lst[i]) begin order.push_back(i); n++; end
    end
    nb    = u ? base + 32'(4 * n) : base - 32'(4 * n);
    first = u ? (p ? base + 32'd4 : base) : (p ? base - 32'(4 * n) : base - 32'(4 * n) + 32'd4);
    has_err = (errbeat >= 0) && (errbeat < n);
    nbeats  = has_err ? errbeat + 1 : n;
    exp_done = 1;
    for (int k = 0; k < nbeats; k++) begin
      d[k] = (dly >= 0) ? dly : int'($urandom_range(2));
      exp_done += d[k] + 1;
      a = first + 32'(4 * k);
      exp_addr.push_back(a);
      exp_data.push_back(ld ? mem_val(a) : snap[order[k]]);
      if (ld && !(has_err && k == errbeat)) begin
        exp_wa.push_back(32'(order[k]));
        exp_wd.push_back(mem_val(a));
      end
    end
    do_wb = !has_err && (n > 0) && w && !(ld && lst[br]);
    if (do_wb) begin
      exp_wa.push_back(32'(br));
      exp_wd.push_back(nb);
      exp_done++;
    end

    @(negedge clk);
    reg_list = lst; is_load = ld; up = u; pre = p; wback = w; base_reg = br; base_val = base;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    reg_list = 16'($urandom); base_val = $urandom; base_reg = 4'($urandom);
    cyc = 1; bi = 0; wc = 0; wi = 0; seen_done = 0;
    while (!seen_done && cyc < 300) begin
      @(negedge clk);
      ack = 0;
      if (bus_if.mem_req && bi < nbeats && wc == d[bi]) ack = 1;
      bus_if.mem_ack   = ack;
      bus_if.mem_err   = ack ? (has_err && bi == errbeat) : 1'($urandom_range(1));
      bus_if.mem_rdata = mem_val(bus_if.mem_addr);
      #1;
      pend = 0;
      if (bus_if.mem_req) begin
        if (bi < nbeats) begin
          check_eq("mem_addr", bus_if.mem_addr, exp_addr[bi]);
          check_eq("mem_we", 32'(bus_if.mem_we), 32'(!ld));
          if (!ld) check_eq("mem_wdata", bus_if.mem_wdata, exp_data[bi]);
        end else begin
          check_eq("extra_req", 32'(bus_if.mem_req), 32'd0);
        end
      end
      if (rf_wr_en) begin
        if (wi < exp_wa.size()) begin
          check_eq("rf_wr_addr", 32'(rf_wr_addr), exp_wa[wi]);
          check_eq("rf_wr_data", rf_wr_data, exp_wd[wi]);
        end else begin
          check_eq("extra_rf_wr", 32'(rf_wr_en), 32'd0);
        end
        wi++;
        pend = 1; pa = rf_wr_addr; pd = rf_wr_data;
      end
      if (done) begin
        seen_done = 1;
        check_eq("done_cycle", 32'(cyc), 32'(exp_done));
        check_eq("err", 32'(err), 32'(has_err));
        check_eq("wr_count", 32'(wi), 32'(exp_wa.size()));
        check_eq("beat_count", 32'(bi), 32'(nbeats));
      end else begin
        check_eq("busy", 32'(busy), 32'd1);
      end
      @(posedge clk);
      if (pend) env_rf[pa] = pd;
      if (ack) begin bi++; wc = 0; end
      else if (bus_if.mem_req) wc++;
      cyc++;
    end
    if (!seen_done) check_eq("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus_if.mem_ack = 1'b0; bus_if.mem_err = 1'b0;
    #1;
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_done", 32'(done), 32'd0);
  endtask

  initial begin
    bus_if.mem_ack   = 1'b0;
    bus_if.mem_err   = 1'b0;
    bus_if.mem_rdata = '0;
    fill_rf();
    #12;
    check_eq("rst_req", 32'(bus_if.mem_req), 32'd0);
    check_eq("rst_addr", bus_if.mem_addr, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_wr", 32'(rf_wr_en), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // STMIA r0!, {r1,r3}
    run_txn(16'h000A, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 32'h0000_1000, 0, -1);
    // LDMDB r13!, {r0,r1,r15}
    run_txn(16'h8003, 1'b1, 1'b0, 1'b1, 1'b1, 4'd13, 32'h0000_2000, 0, -1);
    // LDMIA r2!, {r1,r2}: no write-back, r2 keeps loaded value
    run_txn(16'h0006, 1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 32'h0000_3000, 0, -1);
    check_eq("ldm_base_kept", env_rf[2], mem_val(32'h0000_3004));
    // STMIB with ack held low 3 cycles per beat
    run_txn(16'h0111, 1'b0, 1'b1, 1'b1, 1'b0, 4'd5, 32'h0000_4000, 3, -1);
    // STM with base in list stores the original base
    fill_rf();
    env_rf[4] = 32'h0000_5000;
    run_txn(16'h0030, 1'b0, 1'b1, 1'b0, 1'b1, 4'd4, 32'h0000_5000, 0, -1);
    // Empty list
    run_txn(16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 32'h0000_6000, 0, -1);
    // LDM 4 regs, error on beat 2
    run_txn(16'h00F0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 32'h0000_7000, 0, 1);
    // Decrement wrapping through address zero
    run_txn(16'h0C01, 1'b0, 1'b0, 1'b1, 1'b1, 4'd9, 32'h0000_0004, -1, -1);

    // Reset mid-transfer abandons everything
    @(negedge clk);
    reg_list = 16'h00F0; is_load = 1'b1; up = 1'b1; pre = 1'b0; wback = 1'b1;
    base_reg = 4'd0; base_val = 32'h0000_8000; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    #1;
    check_eq("midxfer_req", 32'(bus_if.mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mrst_req", 32'(bus_if.mem_req), 32'd0);
    check_eq("mrst_busy", 32'(busy), 32'd0);
    check_eq("mrst_wr", 32'(rf_wr_en), 32'd0);
    check_eq("mrst_addr", bus_if.mem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 40; t++) begin
      logic [15:0] l;
      int eb;
      fill_rf();
      case ($urandom_range(5))
        0:       l = 16'h0000;
        1:       l = 16'd1 << $urandom_range(15);
        default: l = 16'($urandom);
      endcase
      eb = ($urandom_range(3) == 0) ? int'($urandom_range(15)) : -1;
      run_txn(l, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
              $urandom & 32'hFFFF_FFFC, -1, eb);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
